// File: rtl/ghost_chase_engine.sv
// ghost_chase_engine: per-ghost chase/stun FSMs stepping toward the player each frame, with hit strobes and proximity LED.
module ghost_chase_engine #(
  parameter int NUM_GHOSTS  = 4,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int GHOST_SIZE  = 32,
  parameter int PLAYER_SIZE = 32,
  parameter int SPEED_BASE  = 1,
  parameter int CLOSE_DIST  = 150,
  parameter int STUN_FRAMES = 60,
  parameter int X_MIN       = 12,
  parameter int X_MAX       = 1250,
  parameter int Y_MIN       = 12,
  parameter int Y_MAX       = 760
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [NUM_GHOSTS-1:0]     enable,
  input  logic [NUM_GHOSTS-1:0]     respawn,
  input  logic [X_W-1:0]            player_x,
  input  logic [Y_W-1:0]            player_y,
  output logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  output logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  output logic [NUM_GHOSTS-1:0]     ghost_active,
  output logic [NUM_GHOSTS-1:0]     ghost_stunned,
  output logic [NUM_GHOSTS-1:0]     hit_pulse,
  output logic                      any_hit,
  output logic [NUM_GHOSTS-1:0]     close,
  output logic                      led_r,
  output logic                      led_g,
  output logic                      led_b
);
  typedef enum logic [1:0] {OFF, CHASE, STUN} state_t;
  localparam int CW = STUN_FRAMES > 1 ? $clog2(STUN_FRAMES) : 1;
  for (genvar i = 0; i < NUM_GHOSTS; i++) begin : gh
    localparam int STEP = SPEED_BASE * (i + 1);
    localparam logic [X_W-1:0] SX = X_W'((i % 2) == 1 ? X_MAX : X_MIN);
    localparam logic [Y_W-1:0] SY = Y_W'((i % 4) >= 2 ? Y_MAX : Y_MIN);
    state_t         st;
    logic [X_W-1:0] gx, nx, dx, sx;
    logic [Y_W-1:0] gy, ny, dy, sy;
    logic [CW-1:0]  cnt;
    logic           hit, cls, near, ovl;
    // Extended-width compares so edge-of-screen sums cannot wrap.
    always_comb begin
      dx   = player_x > gx ? player_x - gx : gx - player_x;
      dy   = player_y > gy ? player_y - gy : gy - player_y;
      sx   = dx < X_W'(STEP) ? dx : X_W'(STEP);
      sy   = dy < Y_W'(STEP) ? dy : Y_W'(STEP);
      nx   = player_x > gx ? gx + sx : gx - sx;
      ny   = player_y > gy ? gy + sy : gy - sy;
      near = 32'(dx) <= CLOSE_DIST && 32'(dy) <= CLOSE_DIST;
      ovl  = ({1'b0, player_x} < {1'b0, gx} + (X_W+1)'(GHOST_SIZE)) &&
             ({1'b0, player_x} + (X_W+1)'(PLAYER_SIZE) > {1'b0, gx}) &&
             ({1'b0, player_y} < {1'b0, gy} + (Y_W+1)'(GHOST_SIZE)) &&
             ({1'b0, player_y} + (Y_W+1)'(PLAYER_SIZE) > {1'b0, gy});
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st  <= OFF;
        gx  <= SX;
        gy  <= SY;
        cnt <= '0;
        hit <= 1'b0;
        cls <= 1'b0;
      end else begin
        hit <= 1'b0;
        cls <= enable[i] && (frame_tick ? (st != OFF && near) : cls);
        if (!enable[i]) begin
          st  <= OFF;
          gx  <= SX;
          gy  <= SY;
          cnt <= '0;
        end else if (respawn[i]) begin
          st  <= CHASE;
          gx  <= SX;
          gy  <= SY;
          cnt <= '0;
        end else if (st == OFF) begin
          st <= CHASE;
        end else if (frame_tick && st == CHASE && ovl) begin
          hit <= 1'b1;
          st  <= STUN;
          cnt <= CW'(STUN_FRAMES - 1);
        end else if (frame_tick && st == CHASE) begin
          gx <= nx;
          gy <= ny;
        end else if (frame_tick && st == STUN) begin
          st  <= cnt == '0 ? CHASE : STUN;
          cnt <= cnt == '0 ? cnt : cnt - 1'b1;
        end
      end
    end
    assign ghost_x[i*X_W +: X_W] = gx;
    assign ghost_y[i*Y_W +: Y_W] = gy;
    assign ghost_active[i]       = st != OFF;
    assign ghost_stunned[i]      = st == STUN;
    assign hit_pulse[i]          = hit;
    assign close[i]              = cls;
  end
  assign any_hit = |hit_pulse;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r <= 1'b0;
      led_g <= 1'b1;
      led_b <= 1'b0;
    end else begin
      led_r <= |close;
      led_b <= !(|close) && |ghost_active;
      led_g <= !(|close) && !(|ghost_active);
    end
  end
endmodule
